// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - multi-cycle multiply/divide engine owning the Hi/Lo register pair
// Shift-add multiply (BITS_PER_CYCLE bits/step) and restoring divide (1 bit/step), sign fixed at the end.
module hilo_muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadReq,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH / BITS_PER_CYCLE);
  localparam logic [CW-1:0] DIV_STEPS = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 divzero_q, divzero_d;

  logic                        is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]            a_mag, b_mag;
  logic [WIDTH+BITS_PER_CYCLE-1:0] partial, upper_sum;
  logic [2*WIDTH-1:0]          mul_next, div_next, prod;
  logic [WIDTH:0]              shifted, diff;
  logic [WIDTH-1:0]            quot, rem;

  // acc holds {partial_product, remaining multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (acc_q[i]) partial = partial + ({{BITS_PER_CYCLE{1'b0}}, opnd_q} << i);
    end
    upper_sum = {{BITS_PER_CYCLE{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + partial;
    mul_next  = {upper_sum, acc_q[WIDTH-1:BITS_PER_CYCLE]};
    shifted   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = shifted - {1'b0, opnd_q};
    div_next  = diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    is_signed = (Op == 3'b000) || (Op == 3'b010);
    a_neg     = is_signed & A[WIDTH-1];
    b_neg     = is_signed & B[WIDTH-1];
    a_mag     = a_neg ? (~A + 1'b1) : A;
    b_mag     = b_neg ? (~B + 1'b1) : B;
    prod      = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quot      = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem       = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (Op)
            3'b000, 3'b001: begin
              acc_d     = {{WIDTH{1'b0}}, b_mag};
              opnd_d    = a_mag;
              is_div_d  = 1'b0;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              dz_d      = 1'b0;
              cnt_d     = MUL_STEPS;
              state_d   = RUN;
            end
            3'b010, 3'b011: begin
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              opnd_d    = b_mag;
              is_div_d  = 1'b1;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              dz_d      = (B == '0);
              cnt_d     = DIV_STEPS;
              state_d   = RUN;
            end
            3'b100:  hi_d = A;
            3'b101:  lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor leaves the dividend magnitude in the remainder, so Hi recovers A after sign fix.
        if (is_div_q) begin
          lo_d = dz_q ? '1 : quot;
          hi_d = rem;
        end else begin
          lo_d = prod[WIDTH-1:0];
          hi_d = prod[2*WIDTH-1:WIDTH];
        end
        done_d    = 1'b1;
        divzero_d = is_div_q & dz_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Stall   = Busy & (Start | ReadReq);
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking scoreboard bench for hilo_muldiv_unit
// Drives a BPC=1 and a BPC=4 instance; expected Hi/Lo/DivZero are queued at issue and popped at Done.
module tb_hilo_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk, rst, start, start4, read_req;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo;
  logic        busy4, stall4, done4, div_zero4;
  logic [31:0] hi4, lo4;

  hilo_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .Clk(clk), .Rst(rst), .Start(start), .Op(op), .A(a), .B(b), .ReadReq(read_req),
    .Busy(busy), .Stall(stall), .Done(done), .DivZero(div_zero), .Hi(hi), .Lo(lo)
  );

  hilo_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .Clk(clk), .Rst(rst), .Start(start4), .Op(op), .A(a), .B(b), .ReadReq(read_req),
    .Busy(busy4), .Stall(stall4), .Done(done4), .DivZero(div_zero4), .Hi(hi4), .Lo(lo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and follows it until Busy drops; A/B are scrambled right after acceptance.
  task automatic run_op(input bit use4, input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        output int cycles, output logic got_done, output logic held,
                        output logic [31:0] r_hi, output logic [31:0] r_lo, output logic r_dz);
    logic [31:0] h0, l0;
    logic        bz;
    @(negedge clk);
    h0 = use4 ? hi4 : hi;
    l0 = use4 ? lo4 : lo;
    if (use4) start4 = 1'b1; else start = 1'b1;
    op = t_op; a = t_a; b = t_b;
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
    a = $urandom; b = $urandom;
    cycles = 0; held = 1'b1;
    bz = use4 ? busy4 : busy;
    while (bz && cycles < 200) begin
      cycles++;
      if ((use4 ? hi4 : hi) !== h0 || (use4 ? lo4 : lo) !== l0) held = 1'b0;
      @(negedge clk);
      bz = use4 ? busy4 : busy;
    end
    got_done = use4 ? done4 : done;
    r_hi = use4 ? hi4 : hi;
    r_lo = use4 ? lo4 : lo;
    r_dz = use4 ? div_zero4 : div_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0; op = 3'b110; a = '0; b = '0; read_req = 1'b0;
    #12;
    checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_busy got busy=%b stall=%b exp 0/0", busy, stall); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo); end
    checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b exp 0/0", done, div_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mult();
    int cyc; logic gd, hd, dz; logic [31:0] rh, rl; exp_t e;
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1, dz: 1'b0});
    run_op(1'b0, 3'b000, 32'hFFFFFFFD, 32'd5, cyc, gd, hd, rh, rl, dz);
    e = sb.pop_front();
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 33", cyc); end
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL mult_done got %b exp 1", gd); end
    checks++; if (rh !== e.hi || rl !== e.lo) begin errors++; $display("FAIL mult_result got %h_%h exp %h_%h", rh, rl, e.hi, e.lo); end
    checks++; if (hd !== 1'b1) begin errors++; $display("FAIL mult_hilo_held got %b exp 1", hd); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", done); end
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1, dz: 1'b0});
    run_op(1'b1, 3'b000, 32'hFFFFFFFD, 32'd5, cyc, gd, hd, rh, rl, dz);
    e = sb.pop_front();
    checks++; if (cyc !== 9) begin errors++; $display("FAIL mult4_busy_cycles got %0d exp 9", cyc); end
    checks++; if (gd !== 1'b1 || rh !== e.hi || rl !== e.lo) begin errors++; $display("FAIL mult4_result got done=%b %h_%h exp %h_%h", gd, rh, rl, e.hi, e.lo); end
  endtask

  task automatic test_divide();
    int cyc; logic gd, hd, dz; logic [31:0] rh, rl; exp_t e;
    sb.push_back('{hi: 32'h2, lo: 32'hE, dz: 1'b0});
    run_op(1'b0, 3'b011, 32'd100, 32'd7, cyc, gd, hd, rh, rl, dz);
    e = sb.pop_front();
    checks++; if (cyc !== 33) begin errors++; $display("FAIL divu_busy_cycles got %0d exp 33", cyc); end
    checks++; if (gd !== 1'b1 || rh !== e.hi || rl !== e.lo || dz !== e.dz) begin errors++; $display("FAIL divu_result got done=%b dz=%b %h/%h exp %h/%h", gd, dz, rh, rl, e.hi, e.lo); end
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dz: 1'b0});
    run_op(1'b0, 3'b010, 32'hFFFFFFF9, 32'd2, cyc, gd, hd, rh, rl, dz);
    e = sb.pop_front();
    checks++; if (gd !== 1'b1 || rh !== e.hi || rl !== e.lo || dz !== e.dz) begin errors++; $display("FAIL div_signed got done=%b dz=%b %h/%h exp %h/%h", gd, dz, rh, rl, e.hi, e.lo); end
  endtask

  task automatic test_div_zero();
    int cyc; logic gd, hd, dz; logic [31:0] rh, rl; exp_t e;
    sb.push_back('{hi: 32'h12345678, lo: 32'hFFFFFFFF, dz: 1'b1});
    run_op(1'b0, 3'b011, 32'h12345678, 32'h0, cyc, gd, hd, rh, rl, dz);
    e = sb.pop_front();
    checks++; if (cyc !== 33) begin errors++; $display("FAIL divzero_cycles got %0d exp 33", cyc); end
    checks++; if (gd !== 1'b1 || dz !== e.dz || rh !== e.hi || rl !== e.lo) begin errors++; $display("FAIL divzero_result got done=%b dz=%b %h/%h exp 1/1 %h/%h", gd, dz, rh, rl, e.hi, e.lo); end
    @(negedge clk);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divzero_pulse got %b exp 0", div_zero); end
    sb.push_back('{hi: 32'h0, lo: 32'h80000000, dz: 1'b0});
    run_op(1'b0, 3'b010, 32'h80000000, 32'hFFFFFFFF, cyc, gd, hd, rh, rl, dz);
    e = sb.pop_front();
    checks++; if (gd !== 1'b1 || dz !== e.dz || rh !== e.hi || rl !== e.lo) begin errors++; $display("FAIL div_overflow got done=%b dz=%b %h/%h exp %h/%h", gd, dz, rh, rl, e.hi, e.lo); end
  endtask

  task automatic test_multu_stall();
    int cyc; int stall_bad; exp_t e;
    sb.push_back('{hi: 32'hFFFFFFFE, lo: 32'h00000001, dz: 1'b0});
    @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0; read_req = 1'b1; cyc = 0; stall_bad = 0;
    while (busy && cyc < 200) begin
      if (stall !== 1'b1) stall_bad++;
      if (cyc == 5) begin start = 1'b1; op = 3'b100; a = 32'hDEADBEEF; end
      else start = 1'b0;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; read_req = 1'b0;
    e = sb.pop_front();
    checks++; if (stall_bad !== 0 || cyc !== 33) begin errors++; $display("FAIL multu_stall got bad=%0d cycles=%0d exp 0/33", stall_bad, cyc); end
    checks++; if (done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL multu_result got done=%b %h_%h exp %h_%h", done, hi, lo, e.hi, e.lo); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b exp 0", stall); end
  endtask

  task automatic test_mtlo();
    logic [31:0] h0;
    h0 = hi;
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'hCAFEF00D || hi !== h0) begin errors++; $display("FAIL mtlo got lo=%h hi=%h exp CAFEF00D %h", lo, hi, h0); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags got busy=%b done=%b exp 0/0", busy, done); end
    start = 1'b1; op = 3'b100; a = 32'h01234567;
    @(negedge clk);
    start = 1'b1; op = 3'b111; a = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'h01234567 || lo !== 32'hCAFEF00D || busy !== 1'b0) begin errors++; $display("FAIL mthi_nop got hi=%h lo=%h busy=%b exp 01234567 CAFEF00D 0", hi, lo, busy); end
  endtask

  task automatic test_back_to_back();
    int cyc; exp_t e;
    sb.push_back('{hi: 32'h2, lo: 32'hE, dz: 1'b0});
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEE, dz: 1'b0});
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    e = sb.pop_front();
    checks++; if (done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL b2b_first got done=%b %h/%h exp %h/%h", done, hi, lo, e.hi, e.lo); end
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'hFFFFFFFE;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy); end
    cyc = 0;
    while (busy && cyc < 200) begin cyc++; @(negedge clk); end
    e = sb.pop_front();
    checks++; if (cyc !== 33 || done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL b2b_second got cyc=%0d done=%b %h_%h exp 33 %h_%h", cyc, done, hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_async_reset();
    int cyc; logic gd, hd, dz; logic [31:0] rh, rl; exp_t e;
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0; read_req = 1'b1;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_rst_flags got busy=%b stall=%b done=%b exp 0", busy, stall, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL async_rst_hilo got %h/%h exp 0/0", hi, lo); end
    @(negedge clk);
    rst = 1'b0; read_req = 1'b0;
    sb.push_back('{hi: 32'h0, lo: 32'h2A, dz: 1'b0});
    run_op(1'b0, 3'b000, 32'd6, 32'd7, cyc, gd, hd, rh, rl, dz);
    e = sb.pop_front();
    checks++; if (cyc !== 33 || gd !== 1'b1 || rh !== e.hi || rl !== e.lo) begin errors++; $display("FAIL post_rst_mult got cyc=%0d done=%b %h_%h exp 33 %h_%h", cyc, gd, rh, rl, e.hi, e.lo); end
  endtask

  task automatic test_random();
    int cyc; logic gd, hd, dz; logic [31:0] rh, rl, ra, rb; logic [2:0] rop; exp_t e;
    longint sp; longint unsigned up; int sq, sr; bit use4;
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      if (i % 3 == 0) begin ra = ra >> 20; rb = rb >> 24; end
      if (rb == 32'h0) rb = 32'd1;
      if (rop == 3'b010 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      use4 = (i >= 7) && (rop[1] == 1'b0);
      case (rop)
        3'b000: begin sp = longint'($signed(ra)) * longint'($signed(rb)); e = '{hi: sp[63:32], lo: sp[31:0], dz: 1'b0}; end
        3'b001: begin up = {32'h0, ra} * {32'h0, rb}; e = '{hi: up[63:32], lo: up[31:0], dz: 1'b0}; end
        3'b010: begin sq = $signed(ra) / $signed(rb); sr = $signed(ra) % $signed(rb); e = '{hi: sr, lo: sq, dz: 1'b0}; end
        default: e = '{hi: ra % rb, lo: ra / rb, dz: 1'b0};
      endcase
      sb.push_back(e);
      run_op(use4, rop, ra, rb, cyc, gd, hd, rh, rl, dz);
      e = sb.pop_front();
      checks++;
      if (gd !== 1'b1 || dz !== e.dz || rh !== e.hi || rl !== e.lo || cyc !== ((use4) ? 9 : 33))
        begin errors++; $display("FAIL random_%0d op=%0d a=%h b=%h got cyc=%0d %h/%h exp %h/%h", i, rop, ra, rb, cyc, rh, rl, e.hi, e.lo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divide();
    test_div_zero();
    test_multu_stall();
    test_mtlo();
    test_back_to_back();
    test_async_reset();
    test_random();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_empty got %0d exp 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
